// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: staged digit inputs + load strobe
// in, scanned anode/segment pins and status out.
interface seg_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                lz_en;
  logic                load;
  logic [DIGITS-1:0]   an;
  logic [7:0]          seg;
  logic                pending;
  logic                frame_done;

  modport master (
    output data, dp, blank, lz_en, load,
    input  an, seg, pending, frame_done
  );

  modport slave (
    input  data, dp, blank, lz_en, load,
    output an, seg, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-seg scanner with frame-synchronous commit.
// Ports: clk, rst (sync, active-high), bus (slave): data/dp/blank/lz_en/load in; an/seg/pending/frame_done out.
module seg_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int DEAD     = 0
) (
  input logic            clk,
  input logic            rst,
  seg_scan_driver_if.slave bus
);
  localparam int PCW = $clog2(SCAN_DIV);
  localparam int IW  = $clog2(DIGITS);

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lz_en;
  } set_t;

  localparam set_t SET_RST = '{
    data:  '0,
    dp:    '0,
    blank: '1,
    lz_en: 1'b0
  };

  logic [PCW-1:0]    pc_q, pc_d;
  logic [IW-1:0]     idx_q, idx_d;
  set_t              s_q, s_d;
  set_t              a_q, a_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  set_t              in_set;
  logic              pc_wrap;
  logic              frame_wrap;
  logic              dead;
  logic              suppress;
  logic [3:0]        nib;
  logic [6:0]        dec;
  logic [DIGITS:0]   zf;

  assign in_set = '{
    data:  bus.data,
    dp:    bus.dp,
    blank: bus.blank,
    lz_en: bus.lz_en
  };

  // Anodes stay off for the first DEAD cycles of each slot.
  if (DEAD == 0) begin : g_nodead
    assign dead = 1'b0;
  end else begin : g_dead
    assign dead = pc_q < PCW'(DEAD);
  end

  // zf[i]: nibbles i..DIGITS-1 of the active set are all zero.
  always_comb begin
    zf = '0;
    zf[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zf[i] = zf[i+1] & (a_q.data[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nib = a_q.data[4*idx_q +: 4];
    dec = 7'h7F;
    unique case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h18;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
    endcase
    suppress = a_q.lz_en && (idx_q != '0) && zf[idx_q];
  end

  always_comb begin
    pc_wrap    = pc_q == PCW'(SCAN_DIV - 1);
    frame_wrap = pc_wrap && (idx_q == IW'(DIGITS - 1));

    pc_d  = pc_wrap ? '0 : pc_q + 1'b1;
    idx_d = idx_q;
    if (pc_wrap) begin
      idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    end

    s_d       = bus.load ? in_set : s_q;
    a_d       = a_q;
    pending_d = pending_q;
    // A load landing on the wrap edge is committed straight through.
    if (frame_wrap) begin
      if (pending_q || bus.load) begin
        a_d = s_d;
      end
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
    frame_done_d = frame_wrap;

    an_d  = '1;
    seg_d = 8'hFF;
    if (!a_q.blank[idx_q] && !dead) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = {~a_q.dp[idx_q], suppress ? 7'h7F : dec};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      idx_q        <= '0;
      s_q          <= SET_RST;
      a_q          <= SET_RST;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      s_q          <= s_d;
      a_q          <= a_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized + directed bench for seg_scan_driver against a cycle-count model.
// DIGITS=4, SCAN_DIV=4, DEAD=1.
module tb_seg_scan_driver;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int DT = 1;
  localparam int FR = D * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_driver_if #(.DIGITS(D)) bus ();

  seg_scan_driver #(
    .DIGITS  (D),
    .SCAN_DIV(SD),
    .DEAD    (DT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] dec_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int         cnt;
  bit         pend;
  logic [15:0] s_data, a_data;
  logic [3:0]  s_dp, a_dp, s_blank, a_blank;
  bit          s_lz, a_lz;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cnt = 0;
    pend = 0;
    s_data = '0; a_data = '0;
    s_dp = '0; a_dp = '0;
    s_blank = '1; a_blank = '1;
    s_lz = 0; a_lz = 0;
  endtask

  task automatic step();
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    logic [6:0]  s7;
    logic [15:0] sh;
    bit          e_fd, wrap;
    int          pc, idx;
    e_an = 4'hF;
    e_seg = 8'hFF;
    e_fd = 0;
    if (rst) begin
      model_reset();
    end else begin
      pc = cnt % SD;
      idx = cnt / SD;
      wrap = (cnt == FR - 1);
      if (!a_blank[idx] && pc >= DT) begin
        e_an = 4'hF ^ (4'd1 << idx);
        sh = a_data >> (4 * idx);
        if (a_lz && idx > 0 && sh == 16'h0) s7 = 7'h7F;
        else s7 = dec_tbl[sh[3:0]];
        e_seg = {~a_dp[idx], s7};
      end
      e_fd = wrap;
      if (bus.load) begin
        s_data = bus.data; s_dp = bus.dp;
        s_blank = bus.blank; s_lz = bus.lz_en;
      end
      if (wrap) begin
        if (bus.load || pend) begin
          a_data = s_data; a_dp = s_dp;
          a_blank = s_blank; a_lz = s_lz;
        end
        pend = 0;
      end else if (bus.load) begin
        pend = 1;
      end
      cnt = (cnt + 1) % FR;
    end
    @(posedge clk);
    #1;
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("frame_done", 32'(bus.frame_done), 32'(e_fd));
    check("pending", 32'(bus.pending), 32'(pend));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align(int target);
    for (int i = 0; i < FR && cnt != target; i++) step();
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] p,
                         logic [3:0] b, logic lz);
    bus.data = d; bus.dp = p; bus.blank = b; bus.lz_en = lz;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    model_reset();
    bus.data = '0; bus.dp = '0; bus.blank = '0;
    bus.lz_en = 1'b0; bus.load = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(40);

    do_load(16'h12AF, 4'b0010, 4'b0000, 1'b0);
    idle(40);

    do_load(16'h0005, 4'b0100, 4'b0000, 1'b1);
    idle(36);

    align(FR - 1);
    do_load(16'hFFFF, 4'b0000, 4'b0000, 1'b0);
    idle(20);

    align(2);
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    idle(3);
    do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    idle(40);

    do_load(16'h8888, 4'b0000, 4'b1000, 1'b0);
    idle(34);
    align(6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(24);

    for (int i = 0; i < 600; i++) begin
      bus.data  = 16'($urandom);
      bus.dp    = 4'($urandom);
      bus.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bus.lz_en = 1'($urandom);
      if ($urandom_range(0, 2) == 0) bus.data[15:8] = 8'h00;
      bus.load  = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    bus.load = 1'b0;
    rst = 1'b0;
    idle(FR * 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
